// File: rtl/mem_pkg.sv
// Shared constants and controller state type for the 16x4 RAM request controller.
package mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Request-side controller for the 16x4 RAM: single-word writes, burst reads with a timed response stream.
// Optional build macro MEM_CTRL_INIT_CLEAR_EN zero-fills the RAM after every reset release.
module mem_ctrl #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);
  import mem_pkg::*;

`ifdef MEM_CTRL_INIT_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] data_q;
  logic              accept;

  // cur doubles as the RAM address and is left on the last driven address,
  // so in IDLE the RAM output stays stable without a separate hold register.
  assign mem_addr = cur;
  assign mem_in   = data_q;

  // Gated by reset_n so every output is 0 while reset is held and load drops at once.
  assign mem_load  = reset_n && (state == WRITE || state == CLEAR);
  assign req_ready = reset_n && (state == IDLE);
  assign busy      = reset_n && (state != IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RST_STATE;
      cur       <= '0;
      cnt       <= '0;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur <= req_addr;
            if (req_write) begin
              data_q <= req_data;
              state  <= WRITE;
            end else begin
              cnt   <= req_len;
              state <= READ;
            end
          end
        end
        WRITE: state <= IDLE;
        READ: begin
          rsp_valid <= 1'b1;
          rsp_data  <= mem_out;
          rsp_last  <= (cnt == '0);
          cnt       <= cnt - 1'b1;
          if (cnt == '0) state <= IDLE;
          else           cur   <= cur + 1'b1;
        end
`ifdef MEM_CTRL_INIT_CLEAR_EN
        CLEAR: begin
          // data_q is zero out of reset, so mem_in already drives the fill value.
          if (cur == '1) state <= IDLE;
          else           cur   <= cur + 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
